// File: rtl/soft_subtractor_seq_pkg.sv
// Shared types and helpers for the chunked soft subtractor.
// State encoding plus chunk-count and index-width helpers.
package quicklogic_soft_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/soft_subtractor_seq_if.sv
// Operand/result valid-ready bundle for soft_subtractor_seq.
// master drives operands and out_ready; slave is the subtractor.
interface soft_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/soft_subtractor_bit.sv
// One-bit subtract cell: d = a - b - bi with borrow-out.
module soft_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/soft_subtractor_seq.sv
// Multi-cycle subtractor resolving CHUNK bits per cycle via a registered borrow.
// Define SOFT_SUBTRACTOR_SATURATE_EN to clamp underflowed results to zero.
import quicklogic_soft_arith_pkg::*;

module soft_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst,
    soft_subtractor_seq_if.slave io
);
    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int KW     = idx_width(NCHUNK);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [CHUNK-1:0] ca, cb, cd;
    logic [CHUNK:0]   chain;

    assign ca       = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign cb       = b_q[int'(k_q)*CHUNK +: CHUNK];
    assign chain[0] = borrow_q;

    // Borrow ripples only across one chunk per cycle.
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        soft_subtractor_bit u_bit (
            .a    (ca[i]),
            .b    (cb[i]),
            .bin  (chain[i]),
            .diff (cd[i]),
            .bout (chain[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d      = io.a;
                    b_d      = io.b;
                    borrow_d = io.bin;
                    k_d      = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[int'(k_q)*CHUNK +: CHUNK] = cd;
                borrow_d = chain[CHUNK];
                if (k_q == KW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    bout_d  = chain[CHUNK];
`ifdef SOFT_SUBTRACTOR_SATURATE_EN
                    if (chain[CHUNK]) diff_d = '0;
`endif
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
endmodule

// File: tb/tb_soft_subtractor_seq.sv
// Directed and randomized checks of soft_subtractor_seq against an arithmetic model.
module tb_soft_subtractor_seq;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    soft_subtractor_seq_if #(.WIDTH(WIDTH)) io ();

    soft_subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Plain-integer model: a - b - bin, unsigned, wrapped to WIDTH bits.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, output logic [WIDTH-1:0] d,
                         output logic bo);
        longint unsigned av, bv;
        av = longint'(a);
        bv = longint'(b) + longint'(bin);
        bo = (av < bv);
        d  = WIDTH'(av - bv);
`ifdef SOFT_SUBTRACTOR_SATURATE_EN
        if (bo) d = '0;
`endif
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] ed,
                          input logic eb, input int hold, input bit junk);
        int lat;
        @(negedge clk);
        check("idle_in_ready", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.a = a;
        io.b = b;
        io.bin = bin;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = junk;
        io.a = WIDTH'($urandom);
        io.b = WIDTH'($urandom);
        io.bin = 1'($urandom);
        check("busy_in_ready", io.in_ready, 0);
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            io.a = WIDTH'($urandom);
            io.b = WIDTH'($urandom);
        end
        check("latency", lat, NCHUNK);
        check("diff", io.diff, ed);
        check("bout", io.bout, eb);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", io.out_valid, 1);
            check("hold_in_ready", io.in_ready, 0);
            check("hold_diff", io.diff, ed);
            check("hold_bout", io.bout, eb);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.out_ready = 1'b0;
        check("post_valid", io.out_valid, 0);
        check("post_in_ready", io.in_ready, 1);
        check("post_diff", io.diff, ed);
        check("post_bout", io.bout, eb);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, md;
        logic             rbin, mb;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.bin = 1'b0;
        io.out_ready = 1'b0;
        #1;
        check("rst_in_ready", io.in_ready, 1);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_diff", io.diff, 0);
        check("rst_bout", io.bout, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 0, 1'b0);
        run_op(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 0, 1'b1);
`ifdef SOFT_SUBTRACTOR_SATURATE_EN
        run_op(16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
`else
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 0, 1'b0);
`endif
        run_op(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 0, 1'b0);
        run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 10, 1'b1);

        // Reset in the second BUSY cycle.
        @(negedge clk);
        io.in_valid = 1'b1;
        io.a = 16'hFFFF;
        io.b = 16'h0001;
        io.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_in_ready", io.in_ready, 1);
        check("abort_out_valid", io.out_valid, 0);
        check("abort_diff", io.diff, 0);
        check("abort_bout", io.bout, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = WIDTH'($urandom);
            rb = (t % 4 == 0) ? ra : WIDTH'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, md, mb);
            run_op(ra, rb, rbin, md, mb, $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
